// File: rtl/pkg_stream_sink.sv
// Receive-side endpoint for the 512-bit packet stream: applies a ready pattern,
// checks framing/sequence/length/keep and collects packet, beat, error and latency stats.
module pkg_stream_sink #(
   parameter int DATA_W = 512,
   parameter int CNT_W  = 32,
   localparam int KEEP_W = DATA_W / 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_start,
   input  logic [31:0]       io_first_seq,
   input  logic [15:0]       io_expect_beats,
   input  logic [CNT_W-1:0]  io_expect_pkts,
   input  logic [7:0]        io_stall_mask,
   input  logic              io_data_in_valid,
   output logic              io_data_in_ready,
   input  logic [DATA_W-1:0] io_data_in_bits_data,
   input  logic [KEEP_W-1:0] io_data_in_bits_keep,
   input  logic              io_data_in_bits_last,
   output logic [CNT_W-1:0]  io_pkt_count,
   output logic [CNT_W-1:0]  io_beat_count,
   output logic [CNT_W-1:0]  io_err_count,
   output logic [2:0]        io_err_flags,
   output logic [CNT_W-1:0]  io_first_latency,
   output logic              io_busy,
   output logic              io_done
);

   typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_DONE} state_t;

   state_t            state_reg, state_next, close_state;
   logic [2:0]        idx_reg, idx_next;
   logic              ready_reg, ready_next;
   logic [31:0]       exp_seq_reg, rx_seq_reg;
   logic [15:0]       exp_beats_reg;
   logic [CNT_W-1:0]  exp_pkts_reg;
   logic [CNT_W-1:0]  pkt_count_reg, beat_count_reg, err_count_reg;
   logic [CNT_W-1:0]  lat_cnt_reg, first_latency_reg, beat_idx_reg;
   logic [2:0]        err_flags_reg;
   logic              got_first_reg, pkt_err_reg;

   logic              busy, start_ok, fire, in_head, last, close_pkt;
   logic [31:0]       seq_in, rx_seq_now;
   logic [CNT_W-1:0]  beat_idx_new, beats_cfg, pkt_count_inc;
   logic              seq_bad, keep_bad, overrun, len_bad, beat_err;
   logic              unused_data;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign busy          = (state_reg == S_HEAD) || (state_reg == S_BODY);
   assign start_ok      = io_start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
   assign fire          = io_data_in_valid && ready_reg;
   assign in_head       = (state_reg == S_HEAD);
   assign last          = io_data_in_bits_last;
   assign close_pkt     = fire && last;
   assign seq_in        = io_data_in_bits_data[DATA_W-1 -: 32];
   assign unused_data   = ^io_data_in_bits_data[DATA_W-33:0];
   assign rx_seq_now    = in_head ? seq_in : rx_seq_reg;
   assign beat_idx_new  = in_head ? CNT_W'(1) : sat_inc(beat_idx_reg);
   assign beats_cfg     = CNT_W'(exp_beats_reg);
   assign pkt_count_inc = sat_inc(pkt_count_reg);

   // Last beat must be a nonzero run of ones from bit 0; earlier beats must be full.
   assign keep_bad = last ? ((io_data_in_bits_keep == '0) ||
                             ((io_data_in_bits_keep & (io_data_in_bits_keep + KEEP_W'(1))) != '0))
                          : (io_data_in_bits_keep != '1);
   assign seq_bad  = in_head && (seq_in != exp_seq_reg);
   assign overrun  = !last && (beat_idx_new > beats_cfg);
   assign len_bad  = last && (beat_idx_new != beats_cfg);
   assign beat_err = seq_bad || keep_bad || overrun || len_bad;

   always_comb begin
      state_next  = state_reg;
      close_state = (pkt_count_inc == exp_pkts_reg) ? S_DONE : S_HEAD;
      idx_next    = idx_reg;
      io_busy     = busy;
      io_done     = (state_reg == S_DONE);
      case (state_reg)
         S_IDLE, S_DONE: if (io_start) state_next = (io_expect_pkts == '0) ? S_DONE : S_HEAD;
         S_HEAD:         if (fire) state_next = last ? close_state : S_BODY;
         S_BODY:         if (close_pkt) state_next = close_state;
         default:        state_next = S_IDLE;
      endcase
      if (start_ok)
         idx_next = 3'd0;
      else if (busy)
         idx_next = idx_reg + 3'd1;
      // Ready is precomputed for the next cycle so it never looks at valid.
      ready_next = ((state_next == S_HEAD) || (state_next == S_BODY)) && io_stall_mask[idx_next];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg         <= S_IDLE;
         idx_reg           <= '0;
         ready_reg         <= 1'b0;
         exp_seq_reg       <= '0;
         rx_seq_reg        <= '0;
         exp_beats_reg     <= '0;
         exp_pkts_reg      <= '0;
         pkt_count_reg     <= '0;
         beat_count_reg    <= '0;
         err_count_reg     <= '0;
         lat_cnt_reg       <= '0;
         first_latency_reg <= '0;
         beat_idx_reg      <= '0;
         err_flags_reg     <= '0;
         got_first_reg     <= 1'b0;
         pkt_err_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         ready_reg <= ready_next;
         if (start_ok) begin
            exp_seq_reg       <= io_first_seq;
            exp_beats_reg     <= io_expect_beats;
            exp_pkts_reg      <= io_expect_pkts;
            pkt_count_reg     <= '0;
            beat_count_reg    <= '0;
            err_count_reg     <= '0;
            lat_cnt_reg       <= '0;
            first_latency_reg <= '0;
            beat_idx_reg      <= '0;
            err_flags_reg     <= '0;
            got_first_reg     <= 1'b0;
            pkt_err_reg       <= 1'b0;
         end else begin
            // The start edge is latency 0, so a beat on the following edge reports 1.
            if (busy && !got_first_reg) begin
               if (fire) begin
                  first_latency_reg <= sat_inc(lat_cnt_reg);
                  got_first_reg     <= 1'b1;
               end else begin
                  lat_cnt_reg <= sat_inc(lat_cnt_reg);
               end
            end
            if (fire) begin
               beat_count_reg <= sat_inc(beat_count_reg);
               beat_idx_reg   <= beat_idx_new;
               err_flags_reg  <= err_flags_reg | {keep_bad, overrun || len_bad, seq_bad};
               if (in_head)
                  rx_seq_reg <= seq_in;
               if (last) begin
                  pkt_count_reg <= pkt_count_inc;
                  if (pkt_err_reg || beat_err)
                     err_count_reg <= sat_inc(err_count_reg);
                  exp_seq_reg <= rx_seq_now + 32'd1;
                  pkt_err_reg <= 1'b0;
               end else begin
                  pkt_err_reg <= pkt_err_reg || beat_err;
               end
            end
         end
      end
   end

   assign io_data_in_ready = ready_reg;
   assign io_pkt_count     = pkt_count_reg;
   assign io_beat_count    = beat_count_reg;
   assign io_err_count     = err_count_reg;
   assign io_err_flags     = err_flags_reg;
   assign io_first_latency = first_latency_reg;

endmodule

// File: tb/tb_pkg_stream_sink.sv
// Directed and randomized sessions for pkg_stream_sink, checked against a
// packet-level model of the expected counters, flags, ready pattern and latency.
module tb_pkg_stream_sink;
   localparam int DATA_W = 512;
   localparam int CNT_W  = 32;
   localparam int KEEP_W = DATA_W / 8;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              io_start = 1'b0;
   logic [31:0]       io_first_seq = '0;
   logic [15:0]       io_expect_beats = '0;
   logic [CNT_W-1:0]  io_expect_pkts = '0;
   logic [7:0]        io_stall_mask = '0;
   logic              io_data_in_valid = 1'b0;
   logic              io_data_in_ready;
   logic [DATA_W-1:0] io_data_in_bits_data = '0;
   logic [KEEP_W-1:0] io_data_in_bits_keep = '0;
   logic              io_data_in_bits_last = 1'b0;
   logic [CNT_W-1:0]  io_pkt_count, io_beat_count, io_err_count, io_first_latency;
   logic [2:0]        io_err_flags;
   logic              io_busy, io_done;

   always #5 clock = ~clock;

   pkg_stream_sink #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .io_start(io_start), .io_first_seq(io_first_seq),
      .io_expect_beats(io_expect_beats), .io_expect_pkts(io_expect_pkts),
      .io_stall_mask(io_stall_mask), .io_data_in_valid(io_data_in_valid),
      .io_data_in_ready(io_data_in_ready), .io_data_in_bits_data(io_data_in_bits_data),
      .io_data_in_bits_keep(io_data_in_bits_keep), .io_data_in_bits_last(io_data_in_bits_last),
      .io_pkt_count(io_pkt_count), .io_beat_count(io_beat_count), .io_err_count(io_err_count),
      .io_err_flags(io_err_flags), .io_first_latency(io_first_latency),
      .io_busy(io_busy), .io_done(io_done)
   );

   typedef struct {
      logic [31:0] seq;
      int          nbeats;
      logic [63:0] keep_last;
      bit          body_bad;
   } pkt_t;

   pkt_t        pkts[$];
   int          tests = 0;
   int          fails = 0;
   int          m_pkts, m_beats, m_errs;
   logic [2:0]  m_flags;
   logic [31:0] m_exp_seq;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ones_n(input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic bit keep_last_ok(input logic [63:0] k);
      for (int n = 1; n <= 64; n++) if (k == ones_n(n)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic add_pkt(input logic [31:0] seq, input int nb, input logic [63:0] kl, input bit bb);
      pkt_t p;
      p.seq = seq; p.nbeats = nb; p.keep_last = kl; p.body_bad = bb;
      pkts.push_back(p);
   endtask

   // Packet-level reference: evaluates a whole packet once its last beat is taken.
   task automatic model_close(input pkt_t p, input int eb);
      bit e = 1'b0;
      if (p.seq != m_exp_seq) begin m_flags[0] = 1'b1; e = 1'b1; end
      m_exp_seq = p.seq + 32'd1;
      if (p.nbeats != eb) begin m_flags[1] = 1'b1; e = 1'b1; end
      if (p.body_bad || !keep_last_ok(p.keep_last)) begin m_flags[2] = 1'b1; e = 1'b1; end
      m_pkts++;
      if (e) m_errs++;
   endtask

   task automatic present(input int pi, input int bi);
      logic [DATA_W-1:0] d;
      pkt_t p = pkts[pi];
      for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
      if (bi == 0) d[DATA_W-1 -: 32] = p.seq;
      io_data_in_bits_data = d;
      io_data_in_bits_last = (bi == p.nbeats - 1);
      if (bi == p.nbeats - 1)
         io_data_in_bits_keep = p.keep_last;
      else if (p.body_bad && bi == 0)
         io_data_in_bits_keep = '1 ^ (64'd1 << $urandom_range(63));
      else
         io_data_in_bits_keep = '1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 64'(io_data_in_ready), 64'd0);
      check({tag, "_pkts"},  64'(io_pkt_count), 64'd0);
      check({tag, "_beats"}, 64'(io_beat_count), 64'd0);
      check({tag, "_errs"},  64'(io_err_count), 64'd0);
      check({tag, "_flags"}, 64'(io_err_flags), 64'd0);
      check({tag, "_lat"},   64'(io_first_latency), 64'd0);
      check({tag, "_busy"},  64'(io_busy), 64'd0);
      check({tag, "_done"},  64'(io_done), 64'd0);
   endtask

   task automatic run_session(input string name, input logic [31:0] fs, input int eb, input int ep,
                              input logic [7:0] mask, input int vdelay, input int gap_pct,
                              input int abort_beat);
      int k = 1, pi = 0, bi = 0, accepted = 0, exp_lat = 0;
      bit got_first = 1'b0, hold = 1'b0, aborted = 1'b0, exp_ready;
      m_pkts = 0; m_beats = 0; m_errs = 0; m_flags = '0; m_exp_seq = fs;
      @(negedge clock);
      io_start = 1'b1; io_first_seq = fs; io_expect_beats = 16'(eb);
      io_expect_pkts = CNT_W'(ep); io_stall_mask = mask; io_data_in_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      io_start = 1'b0;
      while (pi < ep && k < 4000) begin
         exp_ready = mask[(k - 1) % 8];
         check({name, "_ready"}, 64'(io_data_in_ready), 64'(exp_ready));
         check({name, "_busy"},  64'(io_busy), 64'd1);
         check({name, "_beats_run"}, 64'(io_beat_count), 64'(m_beats));
         check({name, "_pkts_run"},  64'(io_pkt_count), 64'(m_pkts));
         check({name, "_errs_run"},  64'(io_err_count), 64'(m_errs));
         if (!hold && k >= vdelay && (!got_first || $urandom_range(99) >= gap_pct)) begin
            present(pi, bi);
            hold = 1'b1;
         end
         io_data_in_valid = hold;
         if (abort_beat >= 0 && accepted == abort_beat && hold) begin
            reset = 1'b0;
            aborted = 1'b1;
            break;
         end
         @(posedge clock);
         if (hold && exp_ready) begin
            accepted++;
            m_beats++;
            if (!got_first) begin got_first = 1'b1; exp_lat = k; end
            if (bi == pkts[pi].nbeats - 1) begin
               model_close(pkts[pi], eb);
               pi++;
               bi = 0;
            end else begin
               bi++;
            end
            hold = 1'b0;
         end
         @(negedge clock);
         k++;
      end
      if (aborted) begin
         @(posedge clock);
         @(negedge clock);
         check_all_zero({name, "_abort"});
         reset = 1'b1;
         io_data_in_valid = 1'b0;
         $display("[TB] %s: reset applied after %0d beats", name, accepted);
         return;
      end
      io_data_in_valid = 1'b0;
      if (k >= 4000) check({name, "_progress"}, 64'(pi), 64'(ep));
      check({name, "_done"},  64'(io_done), 64'd1);
      check({name, "_busy_end"}, 64'(io_busy), 64'd0);
      check({name, "_ready_end"}, 64'(io_data_in_ready), 64'd0);
      check({name, "_pkts"},  64'(io_pkt_count), 64'(m_pkts));
      check({name, "_beats"}, 64'(io_beat_count), 64'(m_beats));
      check({name, "_errs"},  64'(io_err_count), 64'(m_errs));
      check({name, "_flags"}, 64'(io_err_flags), 64'(m_flags));
      check({name, "_lat"},   64'(io_first_latency), 64'(exp_lat));
      repeat (2) begin
         @(negedge clock);
         check({name, "_ready_hold"}, 64'(io_data_in_ready), 64'd0);
         check({name, "_done_hold"},  64'(io_done), 64'd1);
      end
      $display("[TB] %s: pkts=%0d beats=%0d errs=%0d flags=%b lat=%0d", name,
               m_pkts, m_beats, m_errs, m_flags, exp_lat);
   endtask

   task automatic gen_random(input logic [31:0] fs, input int eb, input int ep);
      logic [31:0] s = fs;
      int nb;
      logic [63:0] kl;
      pkts.delete();
      for (int i = 0; i < ep; i++) begin
         if ($urandom_range(99) < 20) s = s + 32'($urandom_range(1, 3));
         nb = eb;
         if ($urandom_range(99) < 20) nb = ($urandom_range(1) == 1) ? eb + 1 : eb - 1;
         if (nb < 1) nb = 2;
         if ($urandom_range(99) < 15) kl = {$urandom, $urandom};
         else kl = ones_n($urandom_range(1, 64));
         add_pkt(s, nb, kl, (nb > 1) && ($urandom_range(99) < 10));
         s = s + 32'd1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int eb, ep;
      logic [7:0] mask;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check_all_zero("reset");
      reset = 1'b1;

      pkts.delete();
      for (int i = 1; i <= 15; i++) add_pkt(32'(i), 2, '1, 1'b0);
      run_session("basic15", 32'd1, 2, 15, 8'hFF, 1, 25, -1);

      pkts.delete();
      add_pkt(32'd7, 1, '1, 1'b0);
      run_session("lat20", 32'd7, 1, 1, 8'hFF, 20, 0, -1);
      run_session("lat1", 32'd7, 1, 1, 8'hFF, 1, 0, -1);

      pkts.delete();
      add_pkt(32'd100, 4, '1, 1'b0);
      run_session("mask55", 32'd100, 4, 1, 8'h55, 1, 0, -1);

      pkts.delete();
      add_pkt(32'd1, 2, '1, 1'b0); add_pkt(32'd2, 2, '1, 1'b0);
      add_pkt(32'd4, 2, '1, 1'b0); add_pkt(32'd5, 2, '1, 1'b0);
      run_session("seqskip", 32'd1, 2, 4, 8'hFF, 1, 10, -1);

      pkts.delete();
      add_pkt(32'd1, 3, 64'h00FF, 1'b0);
      add_pkt(32'd2, 2, 64'h0F0F, 1'b0);
      run_session("len_keep", 32'd1, 2, 2, 8'hFF, 1, 0, -1);

      pkts.delete();
      run_session("zero_pkts", 32'd0, 1, 0, 8'hFF, 1, 0, -1);

      // A zero mask never grants ready; a start pulse while busy must be ignored.
      @(negedge clock);
      io_start = 1'b1; io_first_seq = '0; io_expect_beats = 16'd2;
      io_expect_pkts = CNT_W'(3); io_stall_mask = 8'h00;
      @(posedge clock);
      @(negedge clock);
      io_start = 1'b0;
      io_data_in_valid = 1'b1; io_data_in_bits_keep = '1; io_data_in_bits_last = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         check("mask0_ready", 64'(io_data_in_ready), 64'd0);
         check("mask0_busy", 64'(io_busy), 64'd1);
         check("mask0_beats", 64'(io_beat_count), 64'd0);
         if (c == 10) begin io_start = 1'b1; io_expect_pkts = '0; end
         @(posedge clock);
         @(negedge clock);
         io_start = 1'b0;
      end
      reset = 1'b0;
      io_data_in_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check_all_zero("mask0_reset");
      reset = 1'b1;
      $display("[TB] mask0: stayed busy with ready low for 30 cycles");

      pkts.delete();
      for (int i = 0; i < 5; i++) add_pkt(32'(10 + i), 3, '1, 1'b0);
      run_session("abort", 32'd10, 3, 5, 8'hFF, 1, 0, 7);
      run_session("after_abort", 32'd10, 3, 5, 8'b1011_0111, 2, 20, -1);

      for (int r = 0; r < 4; r++) begin
         eb = $urandom_range(1, 4);
         ep = $urandom_range(3, 8);
         mask = 8'($urandom) | (8'd1 << $urandom_range(7));
         gen_random($urandom, eb, ep);
         run_session($sformatf("rand%0d", r), pkts[0].seq, eb, ep, mask,
                     $urandom_range(1, 10), 30, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
